// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: single-byte I2C master transfer sequencer driving a register-mapped I2C core
module i2c_xfer_seq #(
  parameter logic [7:0]  FDR_VAL  = 8'h07,
  parameter logic [5:0]  ADDR_FDR = 6'h04,
  parameter logic [5:0]  ADDR_CR  = 6'h08,
  parameter logic [5:0]  ADDR_SR  = 6'h0C,
  parameter logic [5:0]  ADDR_DR  = 6'h10,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic       i_sysclk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_rnw,
  input  logic [6:0] i_cmd_saddr,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic [1:0] o_status,
  output logic       o_wr_ena,
  output logic [5:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_ena,
  output logic [5:0] o_rd_addr,
  input  logic [7:0] i_rd_data
);
  localparam logic [4:0] S_INIT_FDR = 5'd0, S_INIT_SR = 5'd1, S_IDLE = 5'd2, S_CR_MEN = 5'd3,
    S_POLL_REQ = 5'd4, S_POLL_WAIT = 5'd5, S_POLL_CHK = 5'd6, S_CR_STA = 5'd7, S_DR_ADDR = 5'd8,
    S_CLR = 5'd9, S_DR_WD = 5'd10, S_CR_TXAK = 5'd11, S_RD_DUMMY = 5'd12, S_CR_B0 = 5'd13,
    S_RD_DATA = 5'd14, S_RD_WAIT = 5'd15, S_RD_LATCH = 5'd16, S_STOP = 5'd17, S_ARB_CR = 5'd18,
    S_ARB_SR = 5'd19, S_TO_CR = 5'd20, S_DONE = 5'd21;
  localparam logic [2:0] PH_START = 3'd0, PH_ADDR = 3'd1, PH_WDAT = 3'd2, PH_RDAT = 3'd3,
    PH_STOP = 3'd4;
  logic [4:0] st, nxt;
  logic [2:0] ph, nph;
  logic [15:0] cnt;
  logic rnw;
  logic [6:0] saddr;
  logic [7:0] wdata;
  logic a_wr, a_rd;
  logic [5:0] a_addr;
  logic [7:0] a_data;
  logic wait_bb, ok, mal, nack, expired, accept;
  // SR bits: 5 MBB, 4 MAL, 1 MIF, 0 RXAK
  assign wait_bb = ph == PH_START || ph == PH_STOP;
  assign ok      = wait_bb ? !i_rd_data[5] : i_rd_data[1];
  assign mal     = !wait_bb && i_rd_data[4];
  assign nack    = (ph == PH_ADDR || ph == PH_WDAT) && i_rd_data[0];
  assign expired = cnt == TIMEOUT - 16'd1;
  assign accept  = st == S_IDLE && i_cmd_valid && o_cmd_ready;
  always_comb begin
    nxt = st;
    nph = ph;
    a_wr = 1'b0;
    a_rd = 1'b0;
    a_addr = '0;
    a_data = '0;
    case (st)
      S_INIT_FDR: begin a_wr = 1'b1; a_addr = ADDR_FDR; a_data = FDR_VAL; nxt = S_INIT_SR; end
      S_INIT_SR:  begin a_wr = 1'b1; a_addr = ADDR_SR; nxt = S_IDLE; end
      S_IDLE:     nxt = accept ? S_CR_MEN : S_IDLE;
      S_CR_MEN:   begin a_wr = 1'b1; a_addr = ADDR_CR; a_data = 8'h80; nph = PH_START; nxt = S_POLL_REQ; end
      S_POLL_REQ: begin a_rd = 1'b1; a_addr = ADDR_SR; nxt = S_POLL_WAIT; end
      S_POLL_WAIT: nxt = S_POLL_CHK;
      S_POLL_CHK: nxt = !ok ? (expired ? S_TO_CR : S_POLL_REQ) :
                        ph == PH_START ? S_CR_STA : ph == PH_STOP ? S_DONE :
                        mal ? S_ARB_CR : nack ? S_STOP : S_CLR;
      S_CR_STA:   begin a_wr = 1'b1; a_addr = ADDR_CR; a_data = 8'hB0; nxt = S_DR_ADDR; end
      S_DR_ADDR:  begin a_wr = 1'b1; a_addr = ADDR_DR; a_data = {saddr, rnw}; nph = PH_ADDR; nxt = S_POLL_REQ; end
      S_CLR: begin
        a_wr = 1'b1;
        a_addr = ADDR_SR;
        nxt = ph == PH_ADDR ? (rnw ? S_CR_TXAK : S_DR_WD) : ph == PH_WDAT ? S_STOP : S_CR_B0;
      end
      S_DR_WD:    begin a_wr = 1'b1; a_addr = ADDR_DR; a_data = wdata; nph = PH_WDAT; nxt = S_POLL_REQ; end
      S_CR_TXAK:  begin a_wr = 1'b1; a_addr = ADDR_CR; a_data = 8'hA8; nxt = S_RD_DUMMY; end
      S_RD_DUMMY: begin a_rd = 1'b1; a_addr = ADDR_DR; nph = PH_RDAT; nxt = S_POLL_REQ; end
      S_CR_B0:    begin a_wr = 1'b1; a_addr = ADDR_CR; a_data = 8'hB0; nxt = S_RD_DATA; end
      S_RD_DATA:  begin a_rd = 1'b1; a_addr = ADDR_DR; nxt = S_RD_WAIT; end
      S_RD_WAIT:  nxt = S_RD_LATCH;
      S_RD_LATCH: nxt = S_STOP;
      S_STOP:     begin a_wr = 1'b1; a_addr = ADDR_CR; a_data = 8'h80; nph = PH_STOP; nxt = S_POLL_REQ; end
      S_ARB_CR:   begin a_wr = 1'b1; a_addr = ADDR_CR; a_data = 8'h80; nxt = S_ARB_SR; end
      S_ARB_SR:   begin a_wr = 1'b1; a_addr = ADDR_SR; nxt = S_DONE; end
      S_TO_CR:    begin a_wr = 1'b1; a_addr = ADDR_CR; nxt = S_DONE; end
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_INIT_FDR;
    endcase
  end
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      st <= S_INIT_FDR;
      ph <= PH_START;
      cnt <= '0;
      rnw <= 1'b0;
      saddr <= '0;
      wdata <= '0;
      o_cmd_ready <= 1'b0;
      o_done <= 1'b0;
      o_rdata <= '0;
      o_status <= '0;
      o_wr_ena <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_rd_ena <= 1'b0;
      o_rd_addr <= '0;
    end else begin
      st <= nxt;
      ph <= nph;
      o_wr_ena <= a_wr;
      o_rd_ena <= a_rd;
      o_wr_addr <= a_addr;
      o_rd_addr <= a_addr;
      o_wr_data <= a_data;
      o_done <= st == S_DONE;
      o_cmd_ready <= st == S_IDLE && !accept;
      cnt <= st == S_POLL_CHK ? cnt + 16'd1 : (st == S_POLL_REQ || st == S_POLL_WAIT) ? cnt : '0;
      if (accept) begin
        rnw <= i_cmd_rnw;
        saddr <= i_cmd_saddr;
        wdata <= i_cmd_wdata;
        o_status <= 2'd0;
      end
      if (st == S_POLL_CHK)
        o_status <= !ok ? (expired ? 2'd3 : o_status) : mal ? 2'd2 : nack ? 2'd1 : o_status;
      if (st == S_RD_LATCH) o_rdata <= i_rd_data;
    end
  end
endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb_i2c_xfer_seq: directed and randomized transfers against a behavioural I2C core and access-list model
module tb_i2c_xfer_seq;
  localparam logic [5:0] A_FDR = 6'h04, A_CR = 6'h08, A_SR = 6'h0C, A_DR = 6'h10;
  localparam int TMO = 20;
  logic clk = 1'b0, i_reset = 1'b1, cmd_valid = 1'b0, cmd_rnw = 1'b0;
  logic [6:0] cmd_saddr = '0;
  logic [7:0] cmd_wdata = '0, i_rd_data = '0;
  logic o_cmd_ready, o_done, o_wr_ena, o_rd_ena;
  logic [7:0] o_rdata, o_wr_data;
  logic [1:0] o_status;
  logic [5:0] o_wr_addr, o_rd_addr;
  always #5 clk = ~clk;
  i2c_xfer_seq #(.TIMEOUT(16'(TMO))) dut (
    .i_sysclk(clk), .i_reset(i_reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_rnw(cmd_rnw), .i_cmd_saddr(cmd_saddr), .i_cmd_wdata(cmd_wdata), .o_done(o_done),
    .o_rdata(o_rdata), .o_status(o_status), .o_wr_ena(o_wr_ena), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_rd_ena(o_rd_ena), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data));
  int checks = 0, errors = 0;
  bit cfg_na, cfg_nd, cfg_mal, cfg_stuck;
  logic [7:0] cfg_rb, exp_rdata = '0;
  // core model: SR flags evolve with accesses, MIF rises a few polls after each byte
  bit c_mif, c_pend, c_mal, c_rxak;
  int c_wait, c_busy, c_nbytes, c_nreads;
  always @(posedge clk) begin
    if (i_reset) begin
      c_mif = 0; c_pend = 0; c_mal = 0; c_rxak = 0; c_busy = 0; c_nbytes = 0; c_nreads = 0;
    end else begin
      if (o_wr_ena && o_wr_addr == A_CR && !o_wr_data[5]) begin
        c_busy = $urandom_range(0, 2); c_nbytes = 0; c_nreads = 0; c_mif = 0; c_pend = 0;
      end
      if (o_wr_ena && o_wr_addr == A_SR) begin c_mif = 0; c_mal = 0; end
      if (o_wr_ena && o_wr_addr == A_DR) begin
        c_rxak = c_nbytes == 0 ? cfg_na : cfg_nd;
        c_mal = c_nbytes == 0 && cfg_mal;
        c_nbytes++; c_pend = 1; c_wait = $urandom_range(0, 3);
      end
      if (o_rd_ena && o_rd_addr == A_SR) begin
        i_rd_data <= {2'b00, cfg_stuck || c_busy > 0, c_mal, 2'b00, c_mif, c_rxak};
        if (c_busy > 0) c_busy--;
        if (c_pend) begin
          if (c_wait == 0) begin c_mif = 1; c_pend = 0; end else c_wait--;
        end
      end
      if (o_rd_ena && o_rd_addr == A_DR) begin
        i_rd_data <= c_nreads == 0 ? ~cfg_rb : cfg_rb;
        if (c_nreads == 0) begin c_pend = 1; c_wait = $urandom_range(0, 3); end
        c_nreads++;
      end
    end
  end
  logic [15:0] log_q[$];
  int polls = 0, done_cnt = 0, both = 0;
  always @(negedge clk) begin
    if (o_wr_ena) log_q.push_back({2'b10, o_wr_addr, o_wr_data});
    if (o_rd_ena && o_rd_addr == A_SR) polls++;
    if (o_rd_ena && o_rd_addr != A_SR) log_q.push_back({2'b00, o_rd_addr, 8'h00});
    if (o_wr_ena && o_rd_ena) both++;
    if (o_done) done_cnt++;
  end
  logic [15:0] exp_q[$];
  function automatic logic [15:0] w(input logic [5:0] a, input logic [7:0] d);
    return {2'b10, a, d};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask
  task automatic cmp_log(input string tag, input int b);
    chk({tag, "_len"}, 32'(log_q.size() - b), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && b + i < log_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(log_q[b + i]), 32'(exp_q[i]));
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!o_cmd_ready && n < 300) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(o_cmd_ready), 32'd1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {o_cmd_ready, o_done, o_rdata, o_status, o_wr_ena, o_rd_ena}, 32'd0);
    chk({tag, "_b"}, {o_wr_addr, o_wr_data, o_rd_addr}, 32'd0);
  endtask
  // expected non-poll register accesses of one command, straight from the transfer rules
  task automatic build_exp(input bit rnw, input logic [6:0] sa, input logic [7:0] wd,
                           input bit na, input bit nd, input bit ml, input bit st);
    exp_q.delete();
    exp_q.push_back(w(A_CR, 8'h80));
    if (st) begin exp_q.push_back(w(A_CR, 8'h00)); return; end
    exp_q.push_back(w(A_CR, 8'hB0));
    exp_q.push_back(w(A_DR, {sa, rnw}));
    if (ml) begin exp_q.push_back(w(A_CR, 8'h80)); exp_q.push_back(w(A_SR, 8'h00)); return; end
    if (na) begin exp_q.push_back(w(A_CR, 8'h80)); return; end
    exp_q.push_back(w(A_SR, 8'h00));
    if (!rnw) begin
      exp_q.push_back(w(A_DR, wd));
      if (!nd) exp_q.push_back(w(A_SR, 8'h00));
    end else begin
      exp_q.push_back(w(A_CR, 8'hA8));
      exp_q.push_back({2'b00, A_DR, 8'h00});
      exp_q.push_back(w(A_SR, 8'h00));
      exp_q.push_back(w(A_CR, 8'hB0));
      exp_q.push_back({2'b00, A_DR, 8'h00});
    end
    exp_q.push_back(w(A_CR, 8'h80));
  endtask
  task automatic run_cmd(input bit rnw, input logic [6:0] sa, input logic [7:0] wd, input logic [7:0] rb,
                         input bit na, input bit nd, input bit ml, input bit st);
    int b, p, d, n;
    logic [1:0] est;
    cfg_na = na; cfg_nd = nd; cfg_mal = ml; cfg_stuck = st; cfg_rb = rb;
    build_exp(rnw, sa, wd, na, nd, ml, st);
    est = st ? 2'd3 : ml ? 2'd2 : na ? 2'd1 : (!rnw && nd) ? 2'd1 : 2'd0;
    if (rnw && est == 2'd0) exp_rdata = rb;
    wait_ready();
    b = log_q.size(); p = polls; d = done_cnt;
    cmd_valid = 1; cmd_rnw = rnw; cmd_saddr = sa; cmd_wdata = wd;
    @(negedge clk);
    chk("ready_drop", 32'(o_cmd_ready), 32'd0);
    cmd_rnw = ~rnw; cmd_saddr = ~sa; cmd_wdata = ~wd;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!o_done && n < 2000) begin @(negedge clk); n++; end
    chk("done_seen", 32'(o_done), 32'd1);
    chk("status", 32'(o_status), 32'(est));
    chk("rdata", 32'(o_rdata), 32'(exp_rdata));
    @(negedge clk);
    chk("done_pulse", 32'(o_done), 32'd0);
    chk("ready_back", 32'(o_cmd_ready), 32'd1);
    chk("done_once", 32'(done_cnt - d), 32'd1);
    cmp_log("seq", b);
    if (st) chk("timeout_polls", 32'(polls - p), 32'(TMO));
  endtask
  initial begin
    int b, d, n;
    bit hit;
    repeat (3) @(negedge clk);
    chk_zero("rst_outs");
    i_reset = 0;
    b = log_q.size();
    wait_ready();
    exp_q.delete();
    exp_q.push_back(w(A_FDR, 8'h07));
    exp_q.push_back(w(A_SR, 8'h00));
    cmp_log("init", b);
    run_cmd(0, 7'h50, 8'hA5, 8'h00, 0, 0, 0, 0);
    run_cmd(1, 7'h50, 8'h00, 8'h3C, 0, 0, 0, 0);
    run_cmd(0, 7'h50, 8'h11, 8'h00, 1, 0, 0, 0);
    run_cmd(1, 7'h22, 8'h00, 8'h77, 1, 0, 0, 0);
    run_cmd(0, 7'h50, 8'h5E, 8'h00, 0, 1, 0, 0);
    run_cmd(1, 7'h50, 8'h00, 8'h99, 0, 0, 1, 0);
    run_cmd(0, 7'h50, 8'h42, 8'h00, 1, 0, 1, 0);
    run_cmd(0, 7'h50, 8'h42, 8'h00, 0, 0, 0, 1);
    run_cmd(1, 7'h7F, 8'h00, 8'hE1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      int r = $urandom_range(0, 6);
      run_cmd(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), r == 0, r == 1, r == 2, r == 3);
    end
    cfg_na = 0; cfg_nd = 0; cfg_mal = 0; cfg_stuck = 0; cfg_rb = 8'h5A;
    run_cmd(1, 7'h33, 8'h00, 8'hC3, 0, 0, 0, 0);
    wait_ready();
    b = log_q.size(); d = done_cnt;
    cmd_valid = 1; cmd_rnw = 1; cmd_saddr = 7'h50;
    @(negedge clk);
    cmd_valid = 0;
    n = 0; hit = 0;
    while (!hit && n < 500) begin
      @(negedge clk); n++;
      for (int i = b; i < log_q.size(); i++) if (log_q[i] == w(A_CR, 8'hA8)) hit = 1;
    end
    chk("read_phase_reached", 32'(hit), 32'd1);
    @(negedge clk);
    #2 i_reset = 1;
    #1 chk_zero("mid_rst_outs");
    repeat (3) @(negedge clk);
    chk_zero("mid_rst_hold");
    i_reset = 0;
    exp_rdata = '0;
    b = log_q.size();
    wait_ready();
    exp_q.delete();
    exp_q.push_back(w(A_FDR, 8'h07));
    exp_q.push_back(w(A_SR, 8'h00));
    cmp_log("reinit", b);
    chk("no_done_abort", 32'(done_cnt - d), 32'd0);
    run_cmd(0, 7'h50, 8'hA5, 8'h00, 0, 0, 0, 0);
    chk("wr_rd_overlap", 32'(both), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 Parameter FDR_VAL, 8'h07, clock divider value written to FDR once after reset.
REQ-002 Parameter ADDR_FDR, 6'h04; ADDR_CR, 6'h08; ADDR_SR, 6'h0C; ADDR_DR, 6'h10; these are the core register addresses.
REQ-003 Parameter TIMEOUT, 16'd50000, the maximum number of SR polls per wait before the transfer aborts.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 i_sysclk  in  1  system clock; all state updates on its rising edge.
REQ-006 i_reset  in  1  asynchronous active-high reset.
REQ-007 i_cmd_valid  in  1  command request.
REQ-008 o_cmd_ready  out  1  sequencer idle and able to accept a command.
REQ-009 i_cmd_rnw  in  1  1 = single-byte read, 0 = single-byte write.
REQ-010 i_cmd_saddr  in  7  7-bit slave address.
REQ-011 i_cmd_wdata  in  8  write byte.
REQ-012 o_done  out  1  one-cycle completion pulse.
REQ-013 o_rdata  out  8  read byte, valid with o_done.
REQ-014 o_status  out  2  result: 0 ok, 1 NACK, 2 arbitration lost, 3 timeout; valid with o_done.
REQ-015 o_wr_ena, o_wr_addr[5:0], o_wr_data[7:0]  out  core register write port.
REQ-016 o_rd_ena, o_rd_addr[5:0]  out  core register read request.
REQ-017 i_rd_data  in  8  read data, valid exactly one cycle after o_rd_ena.

Function
REQ-018 Each bus access asserts o_wr_ena or o_rd_ena for exactly one cycle; the two are never asserted together, and at most one access is outstanding.
REQ-019 After reset the sequencer performs INIT (FDR=FDR_VAL) and then SR=8'h00, then enters IDLE with o_cmd_ready=1.
REQ-020 A command is accepted on a cycle with i_cmd_valid & o_cmd_ready; inputs are latched and o_cmd_ready drops on the next cycle.
REQ-021 Transfer order:
- CR=8'h80 (MEN)
- poll SR until MBB=0
- CR=8'hB0 (MEN|MSTA|MTX)
- DR={saddr,rnw}
- poll SR until MIF=1
- check the result
- SR=8'h00 (clear MIF)
REQ-022 Write data phase: DR=wdata, then poll MIF, check the result, clear MIF, then STOP.
REQ-023 Read data phase, in order:
- CR=8'hA8 (MEN|MSTA|TXAK)
- dummy DR read, data discarded
- poll MIF
- clear MIF
- CR=8'hB0
- DR read latched into o_rdata
- STOP
REQ-024 The check after each MIF poll takes SR bit4 (MAL) first; MAL=1 sets status 2.
REQ-025 On MAL=1 the sequencer writes CR=8'h80 and SR=8'h00 and skips the STOP wait.
REQ-026 If MAL=0 and SR bit0 (RXAK) is 1 after a transmitted byte, status is set to 1 and the sequencer goes to STOP.
REQ-027 STOP: CR=8'h80, then poll SR until MBB=0, then DONE.
REQ-028 DONE: o_done=1 for one cycle, then IDLE with o_cmd_ready=1 on the following cycle.
REQ-029 Each poll loop uses a poll counter that is reset on entering the wait state.
REQ-030 When the poll counter reaches TIMEOUT, status is set to 3, the sequencer writes CR=8'h00, and goes to DONE with no STOP wait.
REQ-031 o_rdata keeps its last value until the next successful read and is not updated on write commands.
REQ-032 i_cmd_valid while busy is ignored, and the command is not queued.

Reset
REQ-033 When i_reset is asserted, all outputs go to 0 at once, including o_cmd_ready, o_rdata and o_status.
REQ-034 Reset asserted mid-transfer abandons the transfer with no o_done, and INIT repeats after release.

Verification
REQ-035 Scenario: reset released -> first accesses are wr FDR=07, then wr SR=00, then o_cmd_ready=1.
REQ-036 Scenario: write saddr=50, wdata=A5, slave ACKs -> access sequence includes DR=A0 and DR=A5, then CR=80; o_done with status 0.
REQ-037 Scenario: read saddr=50, slave returns 3C -> DR=A1, CR=A8, dummy read, CR=B0, o_rdata=3C, status 0.
REQ-038 Scenario: address NACK (RXAK=1) -> no data phase, CR=80 issued, status 1.
REQ-039 Scenario: SR MAL forced high after the address byte -> status 2 with no STOP wait, and MBB held 1 throughout the start wait -> status 3 after TIMEOUT polls.
REQ-040 Scenario: i_reset pulsed during the read data phase -> outputs 0, no o_done, INIT sequence reissued.
